backprop_stack_sequencer: RTL

//  Generates and packs the backprop control bundle consumed by the stack controller.
//  - On start, walks every layer from last down to 0.
//  - Per layer it issues one clear, per-row dC/dW steps, a storage update and a dy/dy_old propagate.
//  - Sits between the top-level training FSM and the backprop stack datapath; it is the producer side of the bundle.

---
 rtl/backprop_stack_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/backprop_stack_sequencer.sv
// Backprop control-bundle producer: walks layers last..0, issuing
// clear, per-row dC/dW, storage update and dy propagate strobes.
`timescale 1ns/1ps
module backprop_stack_sequencer #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int layer_count            = 3,
    parameter int backprop_controll_size = 32*3+4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              hold,
    output logic                              busy,
    output logic                              done,
    output logic [backprop_controll_size-1:0] backprop_controll_bundle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CAL,
        S_STORE,
        S_PROP,
        S_DONE
    } state_t;

    localparam logic [31:0] LAST_LAYER = 32'(layer_count - 1);
    localparam logic [31:0] LAST_ROW   = 32'(size - 1);

    state_t      state_q, state_d;
    logic [31:0] layer_q, layer_d;
    logic [31:0] row_q, row_d;

    logic [31:0] cur_layer;
    logic [31:0] dc_dw_layer;
    logic [31:0] dc_dw_row;
    logic [3:0]  strobe;
    logic [3:0]  strobe_gated;
    logic        done_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            row_q   <= row_d;
        end
    end

    // hold freezes every non-idle state so the stalled step re-issues intact
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        row_d   = row_q;
        if (!hold || state_q == S_IDLE) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        layer_d = LAST_LAYER;
                        row_d   = '0;
                    end
                end
                S_CLEAR: begin
                    state_d = S_CAL;
                end
                S_CAL: begin
                    if (row_q < LAST_ROW) begin
                        row_d = row_q + 32'd1;
                    end else begin
                        row_d   = '0;
                        state_d = S_STORE;
                    end
                end
                S_STORE: begin
                    state_d = (layer_q == '0) ? S_DONE : S_PROP;
                end
                S_PROP: begin
                    layer_d = layer_q - 32'd1;
                    state_d = S_CLEAR;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cur_layer   = '0;
        dc_dw_layer = '0;
        dc_dw_row   = '0;
        strobe      = '0;
        busy        = 1'b0;
        done_raw    = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                cur_layer = layer_q;
                strobe    = 4'b0001;
                busy      = 1'b1;
            end
            S_CAL: begin
                cur_layer   = layer_q;
                dc_dw_layer = layer_q;
                dc_dw_row   = row_q;
                strobe      = 4'b0010;
                busy        = 1'b1;
            end
            S_STORE: begin
                cur_layer   = layer_q;
                dc_dw_layer = layer_q;
                strobe      = 4'b1000;
                busy        = 1'b1;
            end
            S_PROP: begin
                cur_layer = layer_q;
                strobe    = 4'b0100;
                busy      = 1'b1;
            end
            S_DONE: begin
                done_raw = 1'b1;
            end
            default: begin
                done_raw = 1'b0;
            end
        endcase
    end

    assign strobe_gated = hold ? 4'b0000 : strobe;
    assign done         = done_raw & ~hold;

    // a mis-sized bundle parameter leaves the bundle inert instead of misaligned
    if (backprop_controll_size == 100 && data_size > 0) begin : g_pack
        assign backprop_controll_bundle =
            {cur_layer, dc_dw_layer, dc_dw_row, strobe_gated};
    end else begin : g_bad
        assign backprop_controll_bundle = '0;
    end

endmodule
